pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the single-cycle decoder for the 5-stage PC5 core.
- Decodes the instruction in D and carries the control bundle through D/X, X/M and M/W registers.
- Generates load-use stalls, branch/jump flushes and the mult/div start/ready handshake.
- Resolves the writeback destination and the exception code: $r31 for jal, $r30 for setx and overflow.

---
 rtl/pipe_ctrl_unit.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: PC5 decode, D/X-X/M-M/W control pipeline, hazard/flush and mult/div handshake.
module pipe_ctrl_unit #(
    parameter int OPC_W       = 5,
    parameter int RADDR_W     = 5,
    parameter int EXC_W       = 32,
    parameter bit HAS_MULTDIV = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [OPC_W-1:0]   d_opcode,
    input  logic [OPC_W-1:0]   d_aluop,
    input  logic [RADDR_W-1:0] d_rd,
    input  logic [RADDR_W-1:0] d_rs,
    input  logic [RADDR_W-1:0] d_rt,
    input  logic               x_taken,
    input  logic               x_ovf,
    input  logic               md_ready,
    output logic               stall_fd,
    output logic               flush_fd,
    output logic [7:0]         x_ctrl,
    output logic               md_start,
    output logic               m_dmwe,
    output logic               w_rwe,
    output logic               w_rwd,
    output logic [RADDR_W-1:0] w_waddr,
    output logic [EXC_W-1:0]   w_exc,
    output logic               w_exc_sel
);
    localparam logic [RADDR_W-1:0] RA = '1;
    localparam logic [RADDR_W-1:0] RS = RA - 1'b1;

    typedef enum logic {IDLE, BUSY} md_state_e;

    typedef struct packed {
        logic               v;
        logic [7:0]         ctrl;
        logic               rwe, rwd, dmwe, exc_sel, md;
        logic [2:0]         oc;
        logic [RADDR_W-1:0] waddr;
    } dx_t;

    typedef struct packed {
        logic               v, rwe, rwd, dmwe, exc_sel;
        logic [RADDR_W-1:0] waddr;
        logic [EXC_W-1:0]   exc;
    } xm_t;

    typedef struct packed {
        logic               v, rwe, rwd, exc_sel;
        logic [RADDR_W-1:0] waddr;
        logic [EXC_W-1:0]   exc;
    } mw_t;

    dx_t dx_q, dx_d, dec;
    xm_t xm_q, xm_d;
    mw_t mw_q, mw_d;
    md_state_e state_q, state_d;

    logic is_r, md_alu, r_ok, op_add, op_sub, op_mul, op_div;
    logic op_j, op_bne, op_jal, op_jr, op_addi, op_blt, op_sw, op_lw, op_setx, op_bex;
    logic rtarget, uses_a, uses_b, wr;
    logic [RADDR_W-1:0] dst, src_b;
    logic flush, md_hold, load_use;

    always_comb begin
        is_r    = d_opcode == '0;
        md_alu  = d_aluop == OPC_W'(6) || d_aluop == OPC_W'(7);
        r_ok    = is_r && (HAS_MULTDIV || !md_alu);
        op_add  = is_r && d_aluop == OPC_W'(0);
        op_sub  = is_r && d_aluop == OPC_W'(1);
        op_mul  = HAS_MULTDIV && is_r && d_aluop == OPC_W'(6);
        op_div  = HAS_MULTDIV && is_r && d_aluop == OPC_W'(7);
        op_j    = d_opcode == OPC_W'(1);
        op_bne  = d_opcode == OPC_W'(2);
        op_jal  = d_opcode == OPC_W'(3);
        op_jr   = d_opcode == OPC_W'(4);
        op_addi = d_opcode == OPC_W'(5);
        op_blt  = d_opcode == OPC_W'(6);
        op_sw   = d_opcode == OPC_W'(7);
        op_lw   = d_opcode == OPC_W'(8);
        op_setx = d_opcode == OPC_W'(21);
        op_bex  = d_opcode == OPC_W'(22);
        rtarget = op_sw || op_bne || op_blt || op_jr;
        wr      = r_ok || op_addi || op_lw || op_jal || op_setx;
        dst     = op_jal ? RA : op_setx ? RS : d_rd;
        uses_a  = r_ok || op_addi || op_sw || op_lw || op_bne || op_blt || op_jr;
        uses_b  = r_ok || rtarget;
        src_b   = rtarget ? d_rd : d_rt;
        dec.v       = d_valid;
        dec.ctrl    = {!(is_r || op_bne || op_blt || op_bex), rtarget, op_bne || op_blt,
                       op_j, op_jr, op_jal, op_bex, op_setx};
        dec.rwe     = wr && dst != '0;
        dec.rwd     = op_lw;
        dec.dmwe    = op_sw;
        dec.exc_sel = op_setx;
        dec.md      = op_mul || op_div;
        dec.oc      = op_add ? 3'd1 : op_addi ? 3'd2 : op_sub ? 3'd3 : op_mul ? 3'd4 : op_div ? 3'd5 : 3'd0;
        dec.waddr   = dst;
        if (!d_valid) dec = '0;
    end

    always_comb begin
        flush    = dx_q.v && x_taken;
        md_start = state_q == IDLE && dx_q.v && dx_q.md;
        md_hold  = dx_q.v && dx_q.md && (state_q == IDLE || !md_ready);
        load_use = d_valid && dx_q.v && dx_q.rwd && dx_q.waddr != '0 &&
                   ((uses_a && d_rs == dx_q.waddr) || (uses_b && src_b == dx_q.waddr));
        stall_fd = !flush && (md_hold || load_use);
        flush_fd = flush;
        // A held mult/div keeps D/X intact; a load-use or flush replaces it with a bubble.
        dx_d     = flush ? '0 : md_hold ? dx_q : load_use ? '0 : dec;
        state_d  = state_q == IDLE ? (md_start ? BUSY : IDLE) : ((md_ready || flush) ? IDLE : BUSY);
        xm_d     = '0;
        if (dx_q.v && !md_hold) begin
            xm_d.v       = 1'b1;
            xm_d.rwe     = dx_q.rwe;
            xm_d.rwd     = dx_q.rwd;
            xm_d.dmwe    = dx_q.dmwe;
            xm_d.exc_sel = dx_q.exc_sel;
            xm_d.waddr   = dx_q.waddr;
            if (x_ovf && dx_q.oc != '0) begin
                xm_d.rwe     = 1'b1;
                xm_d.rwd     = 1'b0;
                xm_d.exc_sel = 1'b1;
                xm_d.waddr   = RS;
                xm_d.exc     = EXC_W'(dx_q.oc);
            end
        end
        mw_d = '{v: xm_q.v, rwe: xm_q.rwe, rwd: xm_q.rwd, exc_sel: xm_q.exc_sel,
                 waddr: xm_q.waddr, exc: xm_q.exc};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dx_q    <= '0;
            xm_q    <= '0;
            mw_q    <= '0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            xm_q    <= xm_d;
            mw_q    <= mw_d;
        end
    end

    assign x_ctrl    = dx_q.ctrl;
    assign m_dmwe    = xm_q.v && xm_q.dmwe;
    assign w_rwe     = mw_q.v && mw_q.rwe;
    assign w_rwd     = mw_q.v && mw_q.rwd;
    assign w_exc_sel = mw_q.v && mw_q.exc_sel;
    assign w_waddr   = mw_q.waddr;
    assign w_exc     = mw_q.exc;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: vector table of per-cycle stimulus and expected outputs, plus reset-in-BUSY sequence.
module tb_pipe_ctrl_unit;
    logic        clock, reset, d_valid, x_taken, x_ovf, md_ready;
    logic [4:0]  d_opcode, d_aluop, d_rd, d_rs, d_rt;
    logic        stall_fd, flush_fd, md_start, m_dmwe, w_rwe, w_rwd, w_exc_sel;
    logic [7:0]  x_ctrl;
    logic [4:0]  w_waddr;
    logic [31:0] w_exc;
    logic [51:0] act;

    pipe_ctrl_unit dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_opcode(d_opcode), .d_aluop(d_aluop),
        .d_rd(d_rd), .d_rs(d_rs), .d_rt(d_rt), .x_taken(x_taken), .x_ovf(x_ovf), .md_ready(md_ready),
        .stall_fd(stall_fd), .flush_fd(flush_fd), .x_ctrl(x_ctrl), .md_start(md_start),
        .m_dmwe(m_dmwe), .w_rwe(w_rwe), .w_rwd(w_rwd), .w_waddr(w_waddr), .w_exc(w_exc),
        .w_exc_sel(w_exc_sel)
    );

    assign act = {x_ctrl, stall_fd, flush_fd, md_start, m_dmwe, w_rwe, w_rwd, w_exc_sel, w_waddr, w_exc};

    always #5 clock = ~clock;

    typedef struct {
        logic        r, dv;
        logic [4:0]  op, alu, rd, rs, rt;
        logic        tk, ov, rdy;
        logic [51:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [51:0] sb[$];
    int          n_chk = 0, n_fail = 0;

    function automatic logic [51:0] pack_exp(input int xc, st, fl, ms, dm, we, wd, es, wa, ex);
        return {8'(xc), 1'(st), 1'(fl), 1'(ms), 1'(dm), 1'(we), 1'(wd), 1'(es), 5'(wa), 32'(ex)};
    endfunction

    task automatic ins(input int r, op, alu, rd, rs, rt, tk, ov, rdy,
                       input int xc, st, fl, ms, dm, we, wd, es, wa, ex);
        vec_t v;
        v = '{1'(r), 1'b1, 5'(op), 5'(alu), 5'(rd), 5'(rs), 5'(rt), 1'(tk), 1'(ov), 1'(rdy),
              pack_exp(xc, st, fl, ms, dm, we, wd, es, wa, ex)};
        vecs.push_back(v);
    endtask

    task automatic nop(input int tk, ov, rdy, xc, st, fl, ms, dm, we, wd, es, wa, ex);
        vec_t v;
        v = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'(tk), 1'(ov), 1'(rdy),
              pack_exp(xc, st, fl, ms, dm, we, wd, es, wa, ex)};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [51:0] a, input logic [51:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic drive(input logic dv, input logic [4:0] op, alu, rd, rs, rt);
        d_valid = dv; d_opcode = op; d_aluop = alu; d_rd = rd; d_rs = rs; d_rt = rt;
    endtask

    initial begin
        int cnt;
        clock = 0; reset = 1; x_taken = 0; x_ovf = 0; md_ready = 0;
        drive(0, 0, 0, 0, 0, 0);
        #2 chk("reset_outputs", act, '0);
        @(posedge clock); #1 reset = 0;

        // load-use: lw $3 ; add $4,$3,$2
        ins(1, 8,0,3,1,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,4,3,2, 0,0,0, 8'h80, 1,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,4,3,2, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,1,0, 3,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,0, 4,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // taken bne flushes a younger sw
        ins(1, 2,0,1,2,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 7,0,5,6,0, 1,0,0, 8'h60, 0,1,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 1,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // flush wins over a simultaneous load-use
        ins(1, 8,0,3,1,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,4,3,2, 1,0,0, 8'h80, 0,1,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,1,0, 3,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // mul $7 with md_ready 16 cycles after md_start, add $8 waiting in D
        ins(1, 0,6,7,1,2, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,8,9,10, 0,0,0, 8'h00, 1,0,1,0,0,0,0, 0,0);
        for (int k = 2; k <= 16; k++) ins(0, 0,0,8,9,10, 0,0,0, 8'h00, 1,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,8,9,10, 0,0,1, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,0, 7,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,0, 8,0);
        nop(0,0,1, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // overflow on addi then sub
        ins(1, 5,0,12,1,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,1,13,2,3, 0,1,0, 8'h80, 0,0,0,0,0,0,0, 0,0);
        nop(0,1,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,1, 30,2);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,1, 30,3);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // jal, setx, add to $0
        ins(1, 3,0,5,0,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 21,0,0,0,0, 0,0,0, 8'h84, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,0,1,2, 0,0,0, 8'h81, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,0, 31,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,1, 30,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        // non-writing ops and an unknown opcode
        ins(1, 7,0,4,5,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 1,0,0,0,0, 0,0,0, 8'hC0, 0,0,0,0,0,0,0, 0,0);
        ins(0, 4,0,31,0,0, 0,0,0, 8'h90, 0,0,0,1,0,0,0, 0,0);
        ins(0, 22,0,0,0,0, 0,0,0, 8'hC8, 0,0,0,0,0,0,0, 4,0);
        ins(0, 6,0,6,1,2, 0,0,0, 8'h02, 0,0,0,0,0,0,0, 0,0);
        ins(0, 9,0,11,0,0, 0,0,0, 8'h60, 0,0,0,0,0,0,0, 31,0);
        nop(0,0,0, 8'h80, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 6,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 11,0);
        // lw to $0 never stalls; rt-source load-use
        ins(1, 8,0,0,1,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,4,0,0, 0,0,0, 8'h80, 0,0,0,0,0,0,0, 0,0);
        ins(0, 8,0,9,1,0, 0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        ins(0, 0,0,4,1,9, 0,0,0, 8'h80, 1,0,0,0,0,1,0, 0,0);
        ins(0, 0,0,4,1,9, 0,0,0, 8'h00, 0,0,0,0,1,0,0, 4,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,1,0, 9,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);
        nop(0,0,0, 8'h00, 0,0,0,0,1,0,0, 4,0);
        nop(0,0,0, 8'h00, 0,0,0,0,0,0,0, 0,0);

        foreach (vecs[k]) begin
            if (vecs[k].r) begin
                reset = 1;
                @(posedge clock); #1 reset = 0;
            end
            drive(vecs[k].dv, vecs[k].op, vecs[k].alu, vecs[k].rd, vecs[k].rs, vecs[k].rt);
            x_taken = vecs[k].tk; x_ovf = vecs[k].ov; md_ready = vecs[k].rdy;
            sb.push_back(vecs[k].exp);
            @(negedge clock);
            chk($sformatf("vec%0d", k), act, sb.pop_front());
            @(posedge clock); #1;
        end
        x_taken = 0; x_ovf = 0; md_ready = 0;

        // reset during BUSY, then a fresh mul must start exactly once
        reset = 1;
        @(posedge clock); #1 reset = 0;
        drive(1, 0, 6, 7, 1, 2);
        @(posedge clock); #1 drive(0, 0, 0, 0, 0, 0);
        @(negedge clock) chk("md_start_idle", {51'd0, md_start}, 52'd1);
        @(posedge clock); #1;
        @(negedge clock) chk("busy_stall", {51'd0, stall_fd}, 52'd1);
        #2 reset = 1;
        #1 chk("async_reset_busy", act, '0);
        @(posedge clock); #1 reset = 0;
        drive(1, 0, 6, 7, 1, 2);
        @(posedge clock); #1 drive(0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int n = 0; n < 25; n++) begin
            md_ready = (n == 8);
            @(negedge clock) cnt += int'(md_start);
            @(posedge clock); #1;
        end
        md_ready = 0;
        chk("md_start_once", 52'(cnt), 52'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
